// File: rtl/less_than_issuer.sv
// Issue side of a pipelined FP less-than comparator: registers operand pairs onto the comparator,
// tracks tags through a latency-matched delay line and buffers {less, tag} results in a FIFO.
module less_than_issuer #(
  parameter int WIDTH      = 28,
  parameter int TAG_W      = 4,
  parameter int CMP_LAT    = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH:0]   s_a,
  input  logic [WIDTH:0]   s_b,
  input  logic [TAG_W-1:0] s_tag,
  output logic [WIDTH:0]   cmp_a,
  output logic [WIDTH:0]   cmp_b,
  input  logic             cmp_less,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_less,
  output logic [TAG_W-1:0] m_tag,
  output logic [CNT_W-1:0] inflight
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CRD_ONE = 1;
  localparam logic [CNT_W-1:0] CRD_MAX = CNT_W'(FIFO_DEPTH);

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [WIDTH:0]       cmpA_q, cmpA_d;
  logic [WIDTH:0]       cmpB_q, cmpB_d;
  logic [CMP_LAT:0]     dlVld_q, dlVld_d;
  logic [TAG_W-1:0]     dlTag_q [CMP_LAT+1];
  logic [TAG_W-1:0]     dlTag_d [CMP_LAT+1];
  logic [FIFO_DEPTH-1:0] memLess_q;
  logic [TAG_W-1:0]     memTag_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]     rdPtr_q, rdPtr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [CNT_W-1:0]     credits_q, credits_d;

  // A credit covers a pair from acceptance until its result is popped, so the FIFO cannot overflow.
  assign s_ready  = !rst && (credits_q != '0);
  assign accept   = s_valid && s_ready;
  assign push     = dlVld_q[CMP_LAT];
  assign m_valid  = (count_q != '0);
  assign pop      = m_valid && m_ready;
  assign cmp_a    = cmpA_q;
  assign cmp_b    = cmpB_q;
  assign m_less   = m_valid && memLess_q[rdPtr_q];
  assign m_tag    = m_valid ? memTag_q[rdPtr_q] : '0;
  assign inflight = CRD_MAX - credits_q;

  always_comb begin
    cmpA_d    = cmpA_q;
    cmpB_d    = cmpB_q;
    dlVld_d   = {dlVld_q[CMP_LAT-1:0], accept};
    dlTag_d[0] = s_tag;
    for (int i = 1; i <= CMP_LAT; i++) begin
      dlTag_d[i] = dlTag_q[i-1];
    end
    wrPtr_d   = push ? wrPtr_q + PTR_ONE : wrPtr_q;
    rdPtr_d   = pop ? rdPtr_q + PTR_ONE : rdPtr_q;
    count_d   = count_q;
    credits_d = credits_q;
    if (accept) begin
      cmpA_d = s_a;
      cmpB_d = s_b;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    case ({accept, pop})
      2'b10:   credits_d = credits_q - CRD_ONE;
      2'b01:   credits_d = credits_q + CRD_ONE;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmpA_q    <= '0;
      cmpB_q    <= '0;
      dlVld_q   <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      credits_q <= CRD_MAX;
    end else begin
      cmpA_q    <= cmpA_d;
      cmpB_q    <= cmpB_d;
      dlVld_q   <= dlVld_d;
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      credits_q <= credits_d;
    end
  end

  // Payload storage needs no reset: the valid bits and the FIFO count qualify every entry.
  always_ff @(posedge clk) begin
    dlTag_q <= dlTag_d;
    if (push && !rst) begin
      memLess_q[wrPtr_q] <= cmp_less;
      memTag_q[wrPtr_q]  <= dlTag_q[CMP_LAT];
    end
  end
endmodule

// File: tb/tb_less_than_issuer.sv
// Self-checking bench for less_than_issuer with a behavioural 3-stage FP less-than comparator.
module tb_less_than_issuer;
  localparam int WIDTH = 28, TAG_W = 4, CMP_LAT = 3, FIFO_DEPTH = 8, CNT_W = 4;
  localparam logic [WIDTH:0] ONE     = 29'h09FF8000;
  localparam logic [WIDTH:0] TWO     = 29'h0A000000;
  localparam logic [WIDTH:0] NEG_ONE = 29'h0DFF8000;
  localparam logic [WIDTH:0] NEG_TWO = 29'h0E000000;
  localparam logic [WIDTH:0] ZERO    = 29'h00000000;
  localparam logic [WIDTH:0] NAN     = 29'h18000000;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH:0]   s_a;
  logic [WIDTH:0]   s_b;
  logic [TAG_W-1:0] s_tag;
  logic [WIDTH:0]   cmp_a;
  logic [WIDTH:0]   cmp_b;
  logic             cmp_less = 1'b0;
  logic             m_valid;
  logic             m_ready;
  logic             m_less;
  logic [TAG_W-1:0] m_tag;
  logic [CNT_W-1:0] inflight;

  int checks = 0;
  int errors = 0;
  int popCount = 0;
  logic drvExp;

  typedef struct packed {
    logic             less;
    logic [TAG_W-1:0] tag;
  } result_t;
  result_t expQ[$];

  typedef struct {
    logic [WIDTH:0]   a;
    logic [WIDTH:0]   b;
    logic [TAG_W-1:0] tag;
    logic             expLess;
  } vec_t;
  vec_t vecs[7];

  less_than_issuer #(
    .WIDTH(WIDTH), .TAG_W(TAG_W), .CMP_LAT(CMP_LAT), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .s_tag(s_tag), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_less(cmp_less), .m_valid(m_valid),
    .m_ready(m_ready), .m_less(m_less), .m_tag(m_tag), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Ordered compare on exc/sign/exp/frac; NaN never compares less, signed zeros are equal.
  function automatic logic fpLess(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    logic [1:0] ea, eb;
    logic sa, sb;
    logic [26:0] ka, kb;
    ea = a[28:27];
    eb = b[28:27];
    if (ea == 2'b11 || eb == 2'b11) return 1'b0;
    ka = (ea == 2'b10) ? {1'b1, 26'd0} : (ea == 2'b01) ? {1'b0, a[25:0]} : 27'd0;
    kb = (eb == 2'b10) ? {1'b1, 26'd0} : (eb == 2'b01) ? {1'b0, b[25:0]} : 27'd0;
    sa = a[26] && (ea != 2'b00);
    sb = b[26] && (eb != 2'b00);
    if (sa != sb) return sa;
    if (!sa) return ka < kb;
    return ka > kb;
  endfunction

  // Comparator stand-in: result updates CMP_LAT edges after the operands change.
  logic cmpP1 = 1'b0, cmpP2 = 1'b0;
  always @(posedge clk) begin
    cmpP1    <= fpLess(cmp_a, cmp_b);
    cmpP2    <= cmpP1;
    cmp_less <= cmpP2;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every accepted pair is expected back once, in order.
  always @(negedge clk) begin
    result_t e;
    if (rst) begin
      expQ.delete();
    end else begin
      if (m_valid && m_ready) begin
        popCount++;
        if (expQ.size() == 0) begin
          checkOutput("spuriousResult", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sbLess", m_less, e.less);
          checkOutput("sbTag", m_tag, e.tag);
        end
      end
      if (s_valid && s_ready) expQ.push_back(result_t'({drvExp, s_tag}));
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(dut.dlVld_q[CMP_LAT] && dut.count_q == FIFO_DEPTH))
      else begin
        errors++;
        $display("[TB] FAIL fifoOverflow: write into full FIFO, count=%0d", dut.count_q);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setPattern(input int i);
    case (i % 3)
      0:       begin s_a = ONE; s_b = TWO; drvExp = 1'b1; end
      1:       begin s_a = TWO; s_b = ONE; drvExp = 1'b0; end
      default: begin s_a = ONE; s_b = ONE; drvExp = 1'b0; end
    endcase
    s_tag = TAG_W'(i);
  endtask

  task automatic applyStimulus(input logic [WIDTH:0] a, input logic [WIDTH:0] b,
                               input logic [TAG_W-1:0] tag, input logic expLess);
    int lat;
    @(posedge clk); #1;
    s_a = a; s_b = b; s_tag = tag; drvExp = expLess; s_valid = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    checkOutput("sReady", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("cmpA", cmp_a, a);
    checkOutput("cmpB", cmp_b, b);
    checkOutput("inflightOne", inflight, 1);
    lat = -1;
    for (int k = 0; k < 12; k++) begin
      if (m_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    checkOutput("latency", lat, CMP_LAT + 1);
    if (lat >= 0) begin
      checkOutput("mLess", m_less, expLess);
      checkOutput("mTag", m_tag, tag);
      @(negedge clk);
      checkOutput("popEmpty", m_valid, 0);
      checkOutput("inflightZero", inflight, 0);
    end
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (!m_valid && expQ.size() == 0) break;
    end
    checkOutput("drainDone", expQ.size(), 0);
  endtask

  initial begin
    int acc, startPops, notReady;
    logic mvSeen;

    vecs[0] = '{ONE,     TWO,  4'd3,  1'b1};
    vecs[1] = '{ONE,     ONE,  4'd5,  1'b0};
    vecs[2] = '{TWO,     ONE,  4'd6,  1'b0};
    vecs[3] = '{NEG_ONE, ONE,  4'd7,  1'b1};
    vecs[4] = '{NEG_TWO, NEG_ONE, 4'd8, 1'b1};
    vecs[5] = '{ZERO,    ONE,  4'd9,  1'b1};
    vecs[6] = '{NAN,     ONE,  4'd10, 1'b0};

    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_a = '0; s_b = '0; s_tag = '0; drvExp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("readyInReset", s_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstMValid", m_valid, 0);
    checkOutput("rstMLess", m_less, 0);
    checkOutput("rstMTag", m_tag, 0);
    checkOutput("rstInflight", inflight, 0);
    checkOutput("rstCmpA", cmp_a, 0);
    checkOutput("rstCmpB", cmp_b, 0);
    checkOutput("rstReady", s_ready, 1);

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].expLess);

    // Back-to-back stream with an always-ready sink.
    startPops = popCount;
    notReady = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      setPattern(i);
      s_valid = 1'b1;
      @(negedge clk);
      if (!s_ready) notReady++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    drain(40);
    checkOutput("streamNotReady", notReady, 0);
    checkOutput("streamPops", popCount - startPops, 20);

    // Blocked sink: only FIFO_DEPTH pairs may be taken.
    m_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 16 && acc < 10; c++) begin
      @(posedge clk); #1;
      setPattern(acc);
      s_valid = 1'b1;
      @(negedge clk);
      if (s_ready) acc++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("bpAccepted", acc, 8);
    checkOutput("bpReady", s_ready, 0);
    checkOutput("bpInflight", inflight, 8);
    startPops = popCount;
    @(posedge clk); #1;
    m_ready = 1'b1;
    drain(40);
    checkOutput("bpPops", popCount - startPops, 8);
    @(negedge clk);
    checkOutput("bpReadyBack", s_ready, 1);
    checkOutput("bpInflightZero", inflight, 0);

    // Accept and pop in the same cycle with seven results buffered.
    m_ready = 1'b0;
    startPops = popCount;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      setPattern(i);
      s_valid = 1'b1;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (CMP_LAT + 3) @(posedge clk);
    @(negedge clk);
    checkOutput("simInflight7", inflight, 7);
    checkOutput("simMValid", m_valid, 1);
    @(posedge clk); #1;
    setPattern(7);
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("simReady", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    checkOutput("simInflightHold", inflight, 7);
    @(posedge clk); #1;
    m_ready = 1'b1;
    drain(40);
    checkOutput("simPops", popCount - startPops, 8);

    // Mid-operation reset discards everything in flight.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      setPattern(i);
      s_valid = 1'b1;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstReady", s_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mvSeen = 1'b0;
    for (int k = 0; k < CMP_LAT + 2; k++) begin
      @(negedge clk);
      mvSeen = mvSeen | m_valid;
    end
    checkOutput("flushMValid", mvSeen, 0);
    checkOutput("flushInflight", inflight, 0);
    applyStimulus(ONE, TWO, 4'd12, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
